lsu_mem_initiator: RTL and testbench

- Multi-cycle load/store initiator that sits between the core's execute/memory stage and the 32-bit byte-lane data memory.
- The data memory has a combinational read, a word-only synchronous write, and ignores A[1:0].
- This block converts RV32I LB/LH/LW/LBU/LHU/SB/SH/SW requests into word transactions. Sub-word stores use read-modify-write; loads are extracted and extended.
- It flags misaligned, illegal and out-of-range accesses without touching memory.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_align.sv | 39 +++
 rtl/lsu_mem_initiator.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM states and request legality helpers for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    STORE,
    RESP
  } lsu_state_e;

  // Stores have no unsigned variants, so only B/H/W are legal in that direction.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW);
    if (!we) begin
      ok = ok || (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if ((f3 == F3_LH) || (f3 == F3_LHU)) begin
      bad = addr_lo[0];
    end else if (f3 == F3_LW) begin
      bad = (addr_lo != 2'b00);
    end
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane load extraction/extension and store merge for a 32-bit word
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v    = rdata[{addr_lo, 3'b000} +: 8];
    half_v    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{24{byte_v[7]}}, byte_v};
      F3_LH:   load_data = {{16{half_v[15]}}, half_v};
      F3_LBU:  load_data = {24'h0, byte_v};
      F3_LHU:  load_data = {16'h0, half_v};
      default: load_data = rdata;
    endcase
  end

  // funct3[1:0] alone picks the store width; the sign bit does not apply to stores.
  always_comb begin
    merged = rdata;
    case (funct3[1:0])
      2'b00:   merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      2'b01:   merged[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// rtl/lsu_mem_initiator.sv - multi-cycle RV32I load/store initiator onto a word-wide data memory
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic        mem_WE,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_a_q;
  logic [31:0] wr_word_q;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;

  lsu_lane_align u_align (
    .addr_lo   (addr_lo_q),
    .funct3    (f3_q),
    .rdata     (mem_read_data),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  assign accept  = req_valid && (state_q == IDLE);
  assign req_err = !f3_legal(req_we, req_funct3)
                || f3_misaligned(req_funct3, req_addr[1:0])
                || (req_addr >= 32'(MEM_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control outputs decode straight from the state so reset drops mem_WE without a clock.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_WE    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_funct3 == F3_LW) begin
            state_d = STORE;
          end else begin
            state_d = MERGE;
          end
        end
      end
      LOAD:  state_d = RESP;
      MERGE: state_d = STORE;
      STORE: begin
        mem_WE  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response fields change only on the edge into RESP, so they hold between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_lo_q <= 2'b00;
      f3_q      <= 3'b000;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      mem_a_q   <= 32'h0;
      wr_word_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            addr_lo_q <= req_addr[1:0];
            f3_q      <= req_funct3;
            wdata_q   <= req_wdata;
            if (req_err) begin
              rdata_q <= 32'h0;
              err_q   <= 1'b1;
            end else begin
              mem_a_q <= {req_addr[31:2], 2'b00};
              if (req_we && (req_funct3 == F3_LW)) begin
                wr_word_q <= req_wdata;
              end
            end
          end
        end
        LOAD: begin
          rdata_q <= load_data;
          err_q   <= 1'b0;
        end
        MERGE: begin
          wr_word_q <= merged;
        end
        STORE: begin
          rdata_q <= 32'h0;
          err_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_rdata      = rdata_q;
  assign rsp_err        = err_q;
  assign mem_A          = mem_a_q;
  assign mem_write_data = wr_word_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// tb/tb_lsu_mem_initiator.sv - scoreboard bench for lsu_mem_initiator against a byte-array reference
module tb_lsu_mem_initiator;

  localparam int MEM_BYTES = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  always #5 clk = ~clk;

  lsu_mem_initiator #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .mem_A          (mem_A),
    .mem_WE         (mem_WE),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  // Attached memory: combinational read, word write on posedge, A[1:0] ignored.
  logic [7:0] tb_mem [MEM_BYTES];
  assign mem_read_data = {tb_mem[{mem_A[7:2], 2'b11}], tb_mem[{mem_A[7:2], 2'b10}],
                          tb_mem[{mem_A[7:2], 2'b01}], tb_mem[{mem_A[7:2], 2'b00}]};
  always @(posedge clk) begin
    if (mem_WE) begin
      tb_mem[{mem_A[7:2], 2'b00}] <= mem_write_data[7:0];
      tb_mem[{mem_A[7:2], 2'b01}] <= mem_write_data[15:8];
      tb_mem[{mem_A[7:2], 2'b10}] <= mem_write_data[23:16];
      tb_mem[{mem_A[7:2], 2'b11}] <= mem_write_data[31:24];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          acc;
    int          lat;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  logic [7:0] ref_mem [MEM_BYTES];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response or a write.
  always @(negedge clk) begin
    rsp_t e;
    wr_t  w;
    if (rst_n) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
      if (mem_WE) begin
        if (wr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: got mem_WE=1 at %h expected no write (t=%0t)", mem_A, $time);
        end else begin
          w = wr_q.pop_front();
          chk("mem_A", mem_A, w.addr);
          chk("mem_write_data", mem_write_data, w.data);
        end
      end
    end
  end

  task automatic wait_ready(output logic ok);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ok = req_ready;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL req_ready_timeout: got req_ready=0 expected 1 within 50 cycles");
    end
  endtask

  // Reference: access size from funct3, alignment as addr % size, then byte-array arithmetic.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    logic        ok;
    logic        legal;
    logic        err;
    int          size;
    int          base;
    int          acc;
    logic [31:0] word;
    rsp_t        e;
    wr_t         w;
    wait_ready(ok);
    if (!ok) return;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    acc = cyc;

    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    err   = !legal || (addr % size != 0) || (addr >= 32'(MEM_BYTES));
    if (err) begin
      e = '{1'b1, 32'h0, acc, 1};
    end else if (!we) begin
      word = 0;
      for (int i = 0; i < size; i++) word = word | (32'(ref_mem[int'(addr[7:0]) + i]) << (8 * i));
      if (!f3[2] && size < 4 && word[8 * size - 1]) word = word | ~((32'd1 << (8 * size)) - 1);
      e = '{1'b0, word, acc, 2};
    end else begin
      for (int i = 0; i < size; i++) ref_mem[int'(addr[7:0]) + i] = 8'(wdata >> (8 * i));
      base = int'(addr[7:0]) & ~3;
      w.addr = 32'(base);
      w.data = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
      wr_q.push_back(w);
      e = '{1'b0, 32'h0, acc, (size == 4) ? 2 : 3};
    end
    rsp_q.push_back(e);
  endtask

  initial begin
    logic        ok;
    logic [2:0]  f3;
    logic [31:0] a;
    int          r;
    wr_t         w;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_WE", {31'h0, mem_WE}, 32'h0);
    chk("rst_mem_A", mem_A, 32'h0);
    chk("rst_mem_write_data", mem_write_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill all memory through the DUT so both copies start identical.
    for (int i = 0; i < MEM_BYTES / 4; i++) issue(1'b1, 3'b010, 32'(i * 4), $urandom);

    issue(1'b1, 3'b010, 32'h10, 32'h01FF7F80);
    issue(1'b0, 3'b000, 32'h10, 32'h0);
    issue(1'b0, 3'b100, 32'h10, 32'h0);
    issue(1'b0, 3'b001, 32'h12, 32'h0);
    issue(1'b0, 3'b101, 32'h12, 32'h0);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b1, 3'b000, 32'h11, 32'h000000AB);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    issue(1'b1, 3'b010, 32'h20, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h20, 32'h0);
    issue(1'b0, 3'b010, 32'h22, 32'h0);
    issue(1'b1, 3'b001, 32'h13, 32'h1234);
    issue(1'b0, 3'b011, 32'h00, 32'h0);
    issue(1'b0, 3'b010, 32'h100, 32'h0);
    issue(1'b1, 3'b100, 32'h04, 32'h55);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = (r == 0) ? $urandom : (r == 1) ? 32'($urandom_range(256, 300)) : 32'($urandom_range(0, 255));
      r = $urandom_range(0, 9);
      case (r)
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b001;
        4, 5:    f3 = 3'b010;
        6:       f3 = 3'b100;
        7:       f3 = 3'b101;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      issue(1'($urandom_range(0, 1)), f3, a, $urandom);
    end

    // Reset while SW 0x30 sits in STORE: the write must never land.
    wait_ready(ok);
    if (ok) begin
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h30;
      req_wdata  = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      w.addr = 32'h30;
      w.data = 32'hCAFEF00D;
      wr_q.push_back(w);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_mem_WE", {31'h0, mem_WE}, 32'h0);
      chk("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("abort_req_ready", {31'h0, req_ready}, 32'h1);
      issue(1'b0, 3'b010, 32'h30, 32'h0);
    end

    for (int n = 0; n < 20 && (rsp_q.size() != 0 || wr_q.size() != 0); n++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("pending_rsp", 32'(rsp_q.size()), 32'h0);
    chk("pending_wr", 32'(wr_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
